// File: rtl/msg_stream_packer_pkg.sv
// msg_stream_packer_pkg: shared SHA-2 AXIS widths, tuser length field and length helper.
package msg_stream_packer_pkg;
    localparam int BLOCK_DATA_WIDTH = 512;
    localparam int WORDS_DATA_WIDTH = 64;
    localparam int TUSER_WIDTH = 128;
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_MSB = 63;
    typedef logic [TUSER_LEN_MSB-TUSER_LEN_LSB:0] len_t;
    function automatic len_t len_add(input len_t a, input len_t b);
        logic [$bits(len_t):0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[$bits(len_t)] ? '1 : s[$bits(len_t)-1:0];
    endfunction
endpackage

// File: rtl/msg_stream_packer_if.sv
// msg_stream_packer_if: AXIS bundle with master/slave modports.
interface msg_stream_packer_if
    import msg_stream_packer_pkg::*;
#(
    parameter int DW = WORDS_DATA_WIDTH,
    parameter int UW = TUSER_WIDTH
);
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0] tuser;
    logic tvalid;
    logic tready;
    logic tlast;
    modport master(output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave(input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/msg_stream_packer_axis_out_reg.sv
// axis_out_reg: single AXIS output holding register; slot_free tells the producer it may load.
module axis_out_reg
    import msg_stream_packer_pkg::*;
#(
    parameter int DW = BLOCK_DATA_WIDTH,
    parameter int KW = BLOCK_DATA_WIDTH / 8,
    parameter int UW = TUSER_WIDTH
) (
    input logic clk,
    input logic rst_n,
    input logic load,
    input logic [DW-1:0] data,
    input logic [KW-1:0] keep,
    input logic [UW-1:0] user,
    input logic last,
    output logic slot_free,
    msg_stream_packer_if.master m
);
    assign slot_free = !m.tvalid || m.tready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m.tvalid <= 1'b0;
            m.tdata <= '0;
            m.tkeep <= '0;
            m.tuser <= '0;
            m.tlast <= 1'b0;
        end else if (load) begin
            m.tvalid <= 1'b1;
            m.tdata <= data;
            m.tkeep <= keep;
            m.tuser <= user;
            m.tlast <= last;
        end else if (m.tready) begin
            m.tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/msg_stream_packer.sv
// msg_stream_packer: packs a narrow AXIS message stream into hash-block-wide AXIS beats.
// Optional MSG_LEN_TUSER_EN: m_axis tuser low field carries the running message length in bits.
module msg_stream_packer
    import msg_stream_packer_pkg::*;
#(
    parameter int S_AXIS_DATA_WIDTH = WORDS_DATA_WIDTH,
    parameter int M_AXIS_DATA_WIDTH = BLOCK_DATA_WIDTH,
    parameter int AXIS_TUSER_WIDTH = TUSER_WIDTH
) (
    input logic axis_aclk,
    input logic axis_resetn,
    msg_stream_packer_if.slave s_axis,
    msg_stream_packer_if.master m_axis
);
    localparam int SW = S_AXIS_DATA_WIDTH;
    localparam int MW = M_AXIS_DATA_WIDTH;
    localparam int UW = AXIS_TUSER_WIDTH;
    localparam int SK = SW / 8;
    localparam int MK = MW / 8;
    localparam int RATIO = MW / SW;
    localparam int LW = $clog2(RATIO);
    logic [LW-1:0] lane;
    logic [MW-1:0] acc_data, nxt_data, ld_data;
    logic [MK-1:0] acc_keep, nxt_keep, ld_keep;
    logic [UW-1:0] tuser_lat, tuser_cur, blk_user, acc_user, ld_user;
    logic acc_full, acc_last, first, slot_free, take, close, load, ld_last;
    assign s_axis.tready = !acc_full;
    always_comb begin
        take = s_axis.tvalid && !acc_full;
        close = take && (s_axis.tlast || lane == LW'(RATIO - 1));
        nxt_data = acc_data | (MW'(s_axis.tdata) << (int'(lane) * SW));
        nxt_keep = acc_keep | (MK'(s_axis.tkeep) << (int'(lane) * SK));
        tuser_cur = first ? s_axis.tuser : tuser_lat;
        load = slot_free && (acc_full || close);
        ld_data = acc_full ? acc_data : nxt_data;
        ld_keep = acc_full ? acc_keep : nxt_keep;
        ld_user = acc_full ? acc_user : blk_user;
        ld_last = acc_full ? acc_last : s_axis.tlast;
    end
`ifdef MSG_LEN_TUSER_EN
    len_t len_cnt, blk_len;
    always_comb begin
        blk_len = len_add(len_cnt, len_t'($countones(nxt_keep)) << 3);
        blk_user = tuser_cur;
        blk_user[TUSER_LEN_MSB:TUSER_LEN_LSB] = blk_len;
    end
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) len_cnt <= '0;
        else if (close) len_cnt <= s_axis.tlast ? '0 : blk_len;
    end
`else
    assign blk_user = tuser_cur;
`endif
    // a closed block bypasses the accumulator when the output slot is free
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            lane <= '0;
            acc_data <= '0;
            acc_keep <= '0;
            acc_user <= '0;
            acc_full <= 1'b0;
            acc_last <= 1'b0;
            first <= 1'b1;
            tuser_lat <= '0;
        end else if (take) begin
            first <= s_axis.tlast;
            tuser_lat <= tuser_cur;
            lane <= close ? '0 : lane + LW'(1);
            acc_data <= (close && slot_free) ? '0 : nxt_data;
            acc_keep <= (close && slot_free) ? '0 : nxt_keep;
            acc_full <= close && !slot_free;
            acc_last <= s_axis.tlast;
            acc_user <= blk_user;
        end else if (acc_full && slot_free) begin
            acc_full <= 1'b0;
            acc_data <= '0;
            acc_keep <= '0;
        end
    end
    axis_out_reg #(.DW(MW), .KW(MK), .UW(UW)) u_out (
        .clk(axis_aclk),
        .rst_n(axis_resetn),
        .load(load),
        .data(ld_data),
        .keep(ld_keep),
        .user(ld_user),
        .last(ld_last),
        .slot_free(slot_free),
        .m(m_axis)
    );
endmodule

// File: tb/tb_msg_stream_packer.sv
// tb_msg_stream_packer: scoreboard bench for msg_stream_packer (honours MSG_LEN_TUSER_EN).
module tb_msg_stream_packer;
    typedef struct {
        logic [511:0] d;
        logic [63:0] k;
        logic [127:0] u;
        logic l;
    } wbeat_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    wbeat_t exp_q[$];
    logic hold = 1'b0;
    logic [705:0] held;
    msg_stream_packer_if #(.DW(64), .UW(128)) s_axis ();
    msg_stream_packer_if #(.DW(512), .UW(128)) m_axis ();
    msg_stream_packer dut (
        .axis_aclk(clk),
        .axis_resetn(rst_n),
        .s_axis(s_axis),
        .m_axis(m_axis)
    );
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n) hold = 1'b0;
        else begin
            if (hold) begin
                total++;
                if ({m_axis.tvalid, m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} !== held)
                    $display("FAIL hold_stable act=%h req=%h", {m_axis.tvalid, m_axis.tlast, m_axis.tkeep}, held[705:640]);
                if ({m_axis.tvalid, m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata} !== held) bad++;
            end
            hold = m_axis.tvalid && !m_axis.tready;
            held = {m_axis.tvalid, m_axis.tlast, m_axis.tuser, m_axis.tkeep, m_axis.tdata};
            if (m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat keep=%h last=%b", m_axis.tkeep, m_axis.tlast);
                end else begin
                    wbeat_t e;
                    e = exp_q.pop_front();
                    total++;
                    if (m_axis.tdata !== e.d) begin bad++; $display("FAIL beat_data act=%h req=%h", m_axis.tdata, e.d); end
                    total++;
                    if (m_axis.tkeep !== e.k) begin bad++; $display("FAIL beat_keep act=%h req=%h", m_axis.tkeep, e.k); end
                    total++;
                    if (m_axis.tuser !== e.u) begin bad++; $display("FAIL beat_user act=%h req=%h", m_axis.tuser, e.u); end
                    total++;
                    if (m_axis.tlast !== e.l) begin bad++; $display("FAIL beat_last act=%b req=%b", m_axis.tlast, e.l); end
                end
            end
        end
    end

    task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [127:0] u);
        int w = 0;
        s_axis.tdata = d;
        s_axis.tkeep = k;
        s_axis.tlast = l;
        s_axis.tuser = u;
        s_axis.tvalid = 1'b1;
        while (!s_axis.tready && w < 300) begin @(posedge clk); #1; w++; end
        if (w >= 300) begin total++; bad++; $display("FAIL beat_timeout tready=%b req=1", s_axis.tready); end
        @(posedge clk); #1;
    endtask

    task automatic send_pkt(input int n, input logic [127:0] u);
        int nb;
        logic [511:0] bd;
        logic [63:0] bk, bits, d;
        logic [7:0] k;
        wbeat_t e;
        nb = (n == 0) ? 1 : (n + 7) / 8;
        bd = '0; bk = '0; bits = '0;
        for (int b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 8; j++)
                if (b * 8 + j < n) begin d[j*8+:8] = 8'($urandom); k[j] = 1'b1; end
            bd[(b % 8) * 64 +: 64] = d;
            bk[(b % 8) * 8 +: 8] = k;
            bits += 64'($countones(k)) * 8;
            if (b % 8 == 7 || b == nb - 1) begin
                e.d = bd; e.k = bk; e.l = (b == nb - 1);
`ifdef MSG_LEN_TUSER_EN
                e.u = {u[127:64], bits};
`else
                e.u = u;
`endif
                exp_q.push_back(e);
                bd = '0; bk = '0;
            end
            beat(d, k, b == nb - 1, u);
        end
        s_axis.tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL drain pending=%0d req=0", exp_q.size()); end
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (m_axis.tvalid !== 1'b0) begin bad++; $display("FAIL idle_valid act=%b req=0", m_axis.tvalid); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tlast !== 1'b0 || m_axis.tkeep !== '0 || m_axis.tdata !== '0) begin
            bad++; $display("FAIL reset_out valid=%b last=%b keep=%h req=0", m_axis.tvalid, m_axis.tlast, m_axis.tkeep);
        end
        total++;
        if (s_axis.tready !== 1'b1) begin bad++; $display("FAIL reset_tready act=%b req=1", s_axis.tready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_block();
        send_pkt(64, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
        drain();
    endtask

    task automatic test_abc();
        wbeat_t e;
        e.d = '0; e.d[23:0] = 24'h636261; e.k = 64'h7; e.l = 1'b1;
`ifdef MSG_LEN_TUSER_EN
        e.u = {64'hfeed_0000_0000_beef, 64'd24};
`else
        e.u = 128'hfeed_0000_0000_beef_1234_5678_9abc_def0;
`endif
        exp_q.push_back(e);
        beat(64'h636261, 8'h07, 1'b1, 128'hfeed_0000_0000_beef_1234_5678_9abc_def0);
        s_axis.tvalid = 1'b0;
        drain();
    endtask

    task automatic test_three_blocks();
        longint t0;
        t0 = longint'($time);
        send_pkt(130, 128'haaaa_bbbb_cccc_dddd_eeee_ffff_1111_2222);
        total++;
        if (longint'($time) - t0 != 170) begin bad++; $display("FAIL rate_time act=%0d req=170", longint'($time) - t0); end
        drain();
    endtask

    task automatic test_empty_and_lane7();
        send_pkt(0, 128'h5);
        send_pkt(57, 128'h6);
        drain();
    endtask

    task automatic test_backpressure();
        m_axis.tready = 1'b0;
        send_pkt(128, 128'h7777_0000_1234);
        total++;
        if (s_axis.tready !== 1'b0) begin bad++; $display("FAIL bp_tready_drop act=%b req=0", s_axis.tready); end
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (s_axis.tready !== 1'b0 || m_axis.tvalid !== 1'b1) begin
            bad++; $display("FAIL bp_stall tready=%b tvalid=%b req=0/1", s_axis.tready, m_axis.tvalid);
        end
        m_axis.tready = 1'b1;
        drain();
        total++;
        if (s_axis.tready !== 1'b1) begin bad++; $display("FAIL bp_tready_rise act=%b req=1", s_axis.tready); end
    endtask

    task automatic test_midpacket_reset();
        m_axis.tready = 1'b0;
        send_pkt(8, 128'h99);
        for (int b = 0; b < 3; b++) beat(64'hdead_beef_0000_0000 + 64'(b), 8'hff, 1'b0, 128'h42);
        s_axis.tvalid = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== '0 || s_axis.tready !== 1'b1) begin
            bad++; $display("FAIL async_reset tvalid=%b tready=%b req=0/1", m_axis.tvalid, s_axis.tready);
        end
        m_axis.tready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_pkt(5, 128'h1234);
        drain();
    endtask

    task automatic test_back_to_back();
        logic done = 1'b0;
        fork
            begin
                send_pkt(130, 128'h1);
                send_pkt(0, 128'h2);
                send_pkt(64, 128'h3);
                send_pkt(17, 128'h4);
                send_pkt(200, 128'h5);
                done = 1'b1;
            end
            begin
                while (!done) begin @(posedge clk); #1; m_axis.tready = 1'($urandom_range(0, 1)); end
                m_axis.tready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata = '0;
        s_axis.tkeep = '0;
        s_axis.tuser = '0;
        s_axis.tlast = 1'b0;
        m_axis.tready = 1'b1;
        test_reset();
        test_full_block();
        test_abc();
        test_three_blocks();
        test_empty_and_lane7();
        test_backpressure();
        test_midpacket_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
